// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the key matrix scanner and its bench.
package key_scan_pkg;

  localparam int KEY_CODE_MAX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    EVAL,
    NEXT
  } scan_state_t;

  typedef struct packed {
    logic [KEY_CODE_MAX_W-1:0] code;
    logic                      press;
  } key_event_t;

  // $clog2 that never yields a zero-width vector
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all-ones so idle (pulled-up) rows read as released.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_matrix_scanner.sv
// Column-strobed key matrix scanner with per-key scan-count debounce and a
// press/release event stream that stalls the scan rather than drop events.
module key_matrix_scanner
  import key_scan_pkg::*;
#(
  parameter int  ROWS           = 4,
  parameter int  COLS           = 4,
  parameter int  SETTLE_TICKS   = 1000,
  parameter int  DEBOUNCE_SCANS = 4,
  localparam int CODE_W         = clog2_min1(ROWS * COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [COLS-1:0]        col_o,
  input  logic [ROWS-1:0]        row_i,
  output logic [ROWS*COLS-1:0]   state_o,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [CODE_W-1:0]      ev_code,
  output logic                   ev_press
);

  localparam int NKEYS  = ROWS * COLS;
  localparam int COL_W  = clog2_min1(COLS);
  localparam int ROW_W  = clog2_min1(ROWS);
  localparam int TICK_W = clog2_min1(SETTLE_TICKS + 1);
  localparam int CNT_W  = clog2_min1(DEBOUNCE_SCANS + 1);

  if (SETTLE_TICKS < 3 || DEBOUNCE_SCANS < 1) begin : g_bad_params
    $error("key_matrix_scanner: SETTLE_TICKS must be >= 3 and DEBOUNCE_SCANS >= 1");
  end

  scan_state_t       r_fsm;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [TICK_W-1:0] r_tick;
  logic [ROWS-1:0]   r_raw;
  logic [NKEYS-1:0]  r_keys;
  logic [CNT_W-1:0]  r_cnt [NKEYS];
  logic [COLS-1:0]   r_col_o;
  logic              r_ev_valid;
  logic [CODE_W-1:0] r_ev_code;
  logic              r_ev_press;

  logic [ROWS-1:0]   w_row_sync;
  logic [CODE_W-1:0] w_k;
  logic [COL_W-1:0]  w_col_nxt;
  logic              w_differs;
  logic              w_flip;
  logic              w_busy;

  sync_2ff #(.WIDTH(ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .i_d (row_i),
    .o_q (w_row_sync)
  );

  assign w_k       = CODE_W'(int'(r_col) * ROWS + int'(r_row));
  assign w_col_nxt = (int'(r_col) == COLS - 1) ? '0 : r_col + 1'b1;
  assign w_differs = r_raw[r_row] != r_keys[w_k];
  assign w_flip    = w_differs && (int'(r_cnt[w_k]) + 1 >= DEBOUNCE_SCANS);
  assign w_busy    = r_ev_valid && !ev_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm      <= IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_tick     <= '0;
      r_raw      <= '0;
      r_keys     <= '0;
      r_col_o    <= '1;
      r_ev_valid <= 1'b0;
      r_ev_code  <= '0;
      r_ev_press <= 1'b0;
      for (int i = 0; i < NKEYS; i++) r_cnt[i] <= '0;
    end else begin
      if (r_ev_valid && ev_ready) r_ev_valid <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (en) begin
            r_fsm   <= DRIVE;
            r_tick  <= '0;
            r_col_o <= ~(COLS'(1) << r_col);
          end
        end
        DRIVE: begin
          if (int'(r_tick) == SETTLE_TICKS - 1) r_fsm <= SAMPLE;
          else r_tick <= r_tick + 1'b1;
        end
        SAMPLE: begin
          r_raw <= ~w_row_sync;
          r_row <= '0;
          r_fsm <= EVAL;
        end
        EVAL: begin
          // A key that must flip while the slot is still occupied holds the row in place.
          if (!(w_flip && w_busy)) begin
            if (!w_differs) begin
              r_cnt[w_k] <= '0;
            end else if (!w_flip) begin
              r_cnt[w_k] <= r_cnt[w_k] + 1'b1;
            end else begin
              r_keys[w_k] <= ~r_keys[w_k];
              r_cnt[w_k]  <= '0;
              r_ev_valid  <= 1'b1;
              r_ev_code   <= w_k;
              r_ev_press  <= ~r_keys[w_k];
            end
            if (int'(r_row) == ROWS - 1) r_fsm <= NEXT;
            else r_row <= r_row + 1'b1;
          end
        end
        NEXT: begin
          if (en) begin
            r_col   <= w_col_nxt;
            r_fsm   <= DRIVE;
            r_tick  <= '0;
            r_col_o <= ~(COLS'(1) << w_col_nxt);
          end else begin
            r_col   <= '0;
            r_fsm   <= IDLE;
            r_col_o <= '1;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign col_o    = r_col_o;
  assign state_o  = r_keys;
  assign ev_valid = r_ev_valid;
  assign ev_code  = r_ev_code;
  assign ev_press = r_ev_press;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Scoreboard bench: a per-scan debounce model predicts events; a monitor checks the stream.
`timescale 1ns/1ps
module tb_key_matrix_scanner;
  import key_scan_pkg::*;

  localparam int ROWS = 2, COLS = 2, SETTLE = 4, DEB = 3, NK = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            ev_ready;
  logic [COLS-1:0] col_o;
  logic [ROWS-1:0] row_i;
  logic [NK-1:0]   state_o;
  logic            ev_valid;
  logic [1:0]      ev_code;
  logic            ev_press;
  logic [NK-1:0]   key_down = '0;
  bit              rand_ready = 1'b0;
  bit              fixed_ready = 1'b1;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, scan_starts = 0;
  int n_xfer = 0, last_xfer = -10, prev_xfer = -10;

  logic [NK-1:0] m_state;
  int            m_cnt [NK];
  key_event_t    exp_q [$];

  key_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_TICKS(SETTLE), .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .col_o(col_o), .row_i(row_i), .state_o(state_o),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_press(ev_press)
  );

  always #5 clk = ~clk;

  // Passive matrix: a held key pulls its row low only while its column is driven.
  always_comb begin
    row_i = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!col_o[c] && key_down[c*ROWS+r]) row_i[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_state = '0;
    for (int k = 0; k < NK; k++) m_cnt[k] = 0;
    exp_q.delete();
  endfunction

  // One full scan: every key sees the held pattern once, keys visited in index order.
  function automatic void model_scan(input logic [NK-1:0] pat);
    for (int k = 0; k < NK; k++) begin
      if (pat[k] == m_state[k]) m_cnt[k] = 0;
      else begin
        m_cnt[k]++;
        if (m_cnt[k] == DEB) begin
          m_state[k] = pat[k];
          m_cnt[k] = 0;
          exp_q.push_back('{code: KEY_CODE_MAX_W'(k), press: pat[k]});
        end
      end
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : scan_tracker
    logic [COLS-1:0] prev_col;
    prev_col = '1;
    forever begin
      @(posedge clk); #1;
      if (col_o == 2'b10 && prev_col != 2'b10) scan_starts++;
      prev_col = col_o;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    ev_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
  end

  initial begin : monitor
    key_event_t e;
    logic       stall_prev;
    logic [1:0] held_code;
    logic       held_press;
    stall_prev = 1'b0;
    held_code = '0;
    held_press = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) stall_prev = 1'b0;
      else begin
        if (stall_prev) begin
          check("hold_valid", ev_valid, 1'b1);
          check("hold_code", ev_code, held_code);
          check("hold_press", ev_press, held_press);
        end
        if (ev_valid && ev_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got code=%0d press=%0d expected no event (t=%0t)",
                     ev_code, ev_press, $time);
          end else begin
            e = exp_q.pop_front();
            check("ev_code", ev_code, e.code);
            check("ev_press", ev_press, e.press);
          end
          prev_xfer = last_xfer;
          last_xfer = cyc;
          n_xfer++;
        end
        stall_prev = ev_valid && !ev_ready;
        held_code  = ev_code;
        held_press = ev_press;
      end
    end
  end

  task automatic wait_scan_start();
    int s;
    s = scan_starts;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (scan_starts != s) break;
    end
    check("scan_started", scan_starts != s, 1'b1);
  endtask

  task automatic apply_scan(input logic [NK-1:0] pat);
    wait_scan_start();
    check("state_o", state_o, m_state);
    key_down = pat;
    model_scan(pat);
  endtask

  task automatic wait_col(input logic [COLS-1:0] v, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (col_o == v) break;
    end
    check(name, col_o, v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int x0;
    logic [NK-1:0] pat;
    model_reset();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col_o", col_o, 2'b11);
    check("rst_state", state_o, 4'b0000);
    check("rst_valid", ev_valid, 1'b0);
    check("rst_code", ev_code, 2'd0);
    check("rst_press", ev_press, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    en = 1'b1;
    wait_col(2'b10, 2, "release_col0");

    // Reset while a pending event sits in the slot during column 1 drive
    fixed_ready = 1'b0;
    for (int s = 0; s < 3; s++) apply_scan(4'b0001);
    wait_col(2'b01, 40, "reach_col1");
    @(posedge clk); #1;
    check("pending_valid", ev_valid, exp_q.size() != 0);
    #1 rst = 1'b0;
    #1;
    check("abort_col_o", col_o, 2'b11);
    check("abort_valid", ev_valid, 1'b0);
    check("abort_state", state_o, 4'b0000);
    model_reset();
    key_down = '0;
    fixed_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    wait_col(2'b10, 2, "restart_col0");

    // Press key 2
    x0 = n_xfer;
    for (int s = 0; s < 4; s++) apply_scan(4'b0100);
    check("press_events", n_xfer - x0, 1);
    check("press_state", state_o, 4'b0100);

    // Release key 2
    x0 = n_xfer;
    for (int s = 0; s < 4; s++) apply_scan(4'b0000);
    check("release_events", n_xfer - x0, 1);
    check("release_state", state_o, 4'b0000);

    // Bounce key 2 every scan
    x0 = n_xfer;
    for (int s = 0; s < 10; s++) apply_scan((s % 2 == 0) ? 4'b0100 : 4'b0000);
    apply_scan(4'b0000);
    check("bounce_events", n_xfer - x0, 0);
    check("bounce_state", state_o, 4'b0000);

    // Backpressure on two same-column presses
    fixed_ready = 1'b0;
    for (int s = 0; s < 3; s++) apply_scan(4'b0011);
    repeat (20) @(posedge clk);
    #1;
    check("bp_valid", ev_valid, 1'b1);
    check("bp_code", ev_code, 2'd0);
    check("bp_press", ev_press, 1'b1);
    check("bp_col", col_o, 2'b10);
    repeat (10) @(posedge clk);
    #1;
    check("bp_col_frozen", col_o, 2'b10);
    x0 = n_xfer;
    fixed_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("bp_drained", n_xfer - x0, 2);
    check("bp_back_to_back", last_xfer - prev_xfer, 1);
    apply_scan(4'b0011);
    for (int s = 0; s < 4; s++) apply_scan(4'b0000);

    // Enable drop mid-column
    for (int s = 0; s < 5; s++) apply_scan(4'b1000);
    repeat (2) @(posedge clk);
    #1;
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (col_o == 2'b11) break;
      check("en_finish_col", col_o, 2'b10);
    end
    check("en_idle_col", col_o, 2'b11);
    key_down = 4'b0111;
    repeat (20) @(posedge clk);
    #1;
    check("en_idle_state", state_o, m_state);
    check("en_idle_col_held", col_o, 2'b11);
    key_down = 4'b1000;
    en = 1'b1;
    wait_col(2'b10, 2, "en_restart_col0");

    // Randomized patterns with random backpressure
    rand_ready = 1'b1;
    pat = 4'b1000;
    for (int it = 0; it < 25; it++) begin
      pat = NK'($urandom_range(0, 15));
      for (int s = 0, n = $urandom_range(1, 4); s < n; s++) apply_scan(pat);
    end
    rand_ready = 1'b0;
    fixed_ready = 1'b1;
    for (int s = 0; s < 4; s++) apply_scan(pat);
    repeat (30) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
